// File: rtl/spi_eeprom_pkg.sv
// spi_eeprom_pkg: shared definitions for the 25xx-style SPI EEPROM path.
//   - Opcodes (also used by the boot master to build its command byte).
//   - Status register bit indices.
//   - Responder FSM state encoding (3-bit).
package spi_eeprom_pkg;

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;

  localparam int STAT_WIP = 0;
  localparam int STAT_WEL = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer for one asynchronous input plus an
// edge detector on the synchronized level.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input pin
//   level      : synchronized level (2 clk after the pin)
//   rise, fall : single-cycle pulses on synchronized edges
// RST_VAL sets the reset level of the chain, so an idle-high line (ss) does
// not produce a spurious edge or look active right after reset.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_eeprom_responder.sv
// spi_eeprom_responder: SPI mode-0 slave modelling a 25xx serial EEPROM.
// Decodes READ, WRITE, WREN, WRDI, RDSR; storage is preloadable by a host port.
//   clk, reset        : system clock, synchronous active-high reset
//   spi_clk, mosi, ss : SPI pins from the master (asynchronous, SCK <= clk/8)
//   miso, miso_oe     : slave data out and its drive enable
//   mem_we/addr/wdata : host preload port, accepted only while ss is idle
//   wel               : write-enable latch
//   busy              : synchronized ss is low
module spi_eeprom_responder
  import spi_eeprom_pkg::*;
#(
  parameter int DEPTH  = 32768,
  parameter int PAGE   = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic              miso_oe,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_wdata,
  output logic              wel,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] PG_MASK = ADDR_W'(PAGE - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_s, ss_rise, ss_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sck  (.clk(clk), .reset(reset), .d(spi_clk),
                                          .level(sck_lvl), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .reset(reset), .d(mosi),
                                          .level(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss   (.clk(clk), .reset(reset), .d(ss),
                                          .level(ss_s), .rise(ss_rise), .fall(ss_fall));

  logic sync_unused;
  assign sync_unused = ^{sck_lvl, mosi_rise, mosi_fall, ss_rise, ss_fall};

  state_t            state, state_nxt;
  logic [2:0]        bit_cnt, tx_cnt;
  logic [7:0]        shreg, tx, addr_hi, rd_byte, out_byte, status;
  logic [7:0]        rx_byte;
  logic [15:0]       full_addr;
  logic [ADDR_W-1:0] addr, addr_inc, addr_pg;
  logic              rd_op, wr_done, byte_done;
  logic              wel_set, wel_clr, commit;
  logic              host_ok, mem_wr;
  logic [ADDR_W-1:0] mem_wa;
  logic [7:0]        mem_wd;
  logic [7:0]        mem [0:DEPTH-1];

  assign rx_byte   = {shreg[6:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign full_addr = {addr_hi, rx_byte};
  assign addr_inc  = addr + ADDR_W'(1);
  // Write streaming wraps inside the current page; upper address bits hold.
  assign addr_pg   = (addr & ~PG_MASK) | (addr_inc & PG_MASK);
  assign status    = 8'(wel) << STAT_WEL;
  assign rd_byte   = mem[addr];
  assign out_byte  = (state == ST_STATUS) ? status : rd_byte;
  assign busy      = ~ss_s;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wel_set   = 1'b0;
    wel_clr   = 1'b0;
    commit    = 1'b0;
    if (ss_s) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_CMD;
        ST_CMD: if (byte_done) begin
          case (rx_byte)
            OP_READ, OP_WRITE: state_nxt = ST_ADDR_HI;
            OP_WREN: begin wel_set = 1'b1; state_nxt = ST_IGNORE; end
            OP_WRDI: begin wel_clr = 1'b1; state_nxt = ST_IGNORE; end
            OP_RDSR: state_nxt = ST_STATUS;
            default: state_nxt = ST_IGNORE;
          endcase
        end
        ST_ADDR_HI: if (byte_done) state_nxt = ST_ADDR_LO;
        ST_ADDR_LO: if (byte_done)
          state_nxt = rd_op ? ST_RD_DATA : (wel ? ST_WR_DATA : ST_IGNORE);
        ST_WR_DATA: if (byte_done) commit = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      tx_cnt  <= '0;
      shreg   <= '0;
      tx      <= '0;
      addr_hi <= '0;
      addr    <= '0;
      rd_op   <= 1'b0;
      wel     <= 1'b0;
      wr_done <= 1'b0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
    end else if (ss_s) begin
      // Frame over: drop any partial byte; a committed write closes the latch.
      bit_cnt <= '0;
      tx_cnt  <= '0;
      miso    <= 1'b0;
      miso_oe <= 1'b0;
      wr_done <= 1'b0;
      if (wr_done) wel <= 1'b0;
    end else begin
      if (sck_rise) begin
        shreg   <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == ST_CMD && byte_done)     rd_op   <= (rx_byte == OP_READ);
      if (state == ST_ADDR_HI && byte_done) addr_hi <= rx_byte;
      if (state == ST_ADDR_LO && byte_done) addr    <= full_addr[ADDR_W-1:0];
      if (wel_set) wel <= 1'b1;
      if (wel_clr) wel <= 1'b0;
      if (commit) begin
        addr    <= addr_pg;
        wr_done <= 1'b1;
      end
      // Output byte is fetched on its first fall, so one read port suffices.
      if (sck_fall && (state == ST_RD_DATA || state == ST_STATUS)) begin
        miso_oe <= 1'b1;
        if (tx_cnt == 3'd0) begin
          miso <= out_byte[7];
          tx   <= {out_byte[6:0], 1'b0};
        end else begin
          miso <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
        tx_cnt <= tx_cnt + 3'd1;
        if (tx_cnt == 3'd7 && state == ST_RD_DATA) addr <= addr_inc;
      end
    end
  end

  // SPI commits need ss low, host writes need ss high: never both at once.
  assign host_ok = mem_we & ss_s;
  assign mem_wr  = commit | host_ok;
  assign mem_wa  = commit ? addr : mem_addr;
  assign mem_wd  = commit ? rx_byte : mem_wdata;

  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_wa] <= mem_wd;
  end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
module tb_spi_eeprom_responder;

  logic        clk = 1'b0;
  logic        reset, spi_clk, mosi, ss, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        miso, miso_oe, wel, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  spi_eeprom_responder dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .mosi(mosi), .ss(ss),
    .miso(miso), .miso_oe(miso_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wel(wel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_wr(input logic [14:0] a, input logic [7:0] d);
    mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick(1);
    mem_we = 1'b0;
  endtask

  task automatic spi_begin;
    ss = 1'b0;
    tick(6);
  endtask

  task automatic spi_end;
    tick(6);
    ss = 1'b1;
    tick(8);
    chk("idle_miso", miso, 1'b0);
  endtask

  // Mode 0: mosi set while SCK low, miso sampled at the SCK rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          output logic oe_all, output logic oe_any);
    rx = '0; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < n; i++) begin
      mosi = tx[7-i];
      tick(5);
      spi_clk = 1'b1;
      rx = {rx[6:0], miso};
      oe_all &= miso_oe;
      oe_any |= miso_oe;
      tick(5);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cmd_byte(input logic [7:0] b);
    logic [7:0] rx;
    logic all, any;
    spi_bits(b, 8, rx, all, any);
    chk("cmd_oe", any, 1'b0);
  endtask

  task automatic read_bytes(input int n, input string tag);
    logic [7:0] rx, exp;
    logic all, any;
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, rx, all, any);
      chk("data_oe", all, 1'b1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk(tag, rx, exp);
    end
  endtask

  task automatic spi_read(input logic [15:0] a, input int n, input string tag);
    spi_begin;
    chk("busy", busy, 1'b1);
    cmd_byte(8'h03); cmd_byte(a[15:8]); cmd_byte(a[7:0]);
    read_bytes(n, tag);
    spi_end;
  endtask

  task automatic spi_op(input logic [7:0] op);
    spi_begin; cmd_byte(op); spi_end;
  endtask

  task automatic spi_write(input logic [15:0] a, input logic [31:0] d, input int n);
    spi_begin;
    cmd_byte(8'h02); cmd_byte(a[15:8]); cmd_byte(a[7:0]);
    for (int i = 0; i < n; i++) cmd_byte(d[31-8*i -: 8]);
    spi_end;
  endtask

  initial begin
    logic [7:0] rx;
    logic all, any;
    reset = 1'b1; ss = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    tick(3);
    chk("rst_miso", miso, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_wel", wel, 1'b0);
    chk("rst_busy", busy, 1'b0);

    // Preload during reset is honoured
    for (int i = 0; i < 8; i++) host_wr(15'(i), 8'(8'h11 * (i + 1)));
    reset = 1'b0;
    tick(4);

    // 1: basic READ
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
    spi_read(16'h0000, 4, "t1_read");

    // 2: READ across DEPTH wrap
    host_wr(15'h7FFF, 8'hAB); host_wr(15'h0000, 8'hCD);
    sb.push_back(8'hAB); sb.push_back(8'hCD);
    spi_read(16'h7FFF, 2, "t2_wrap");

    // 3: WRITE without WREN, WREN, RDSR, WRITE with WREN
    host_wr(15'h0010, 8'h77);
    spi_write(16'h0010, 32'h5A000000, 1);
    chk("t3_wel_off", wel, 1'b0);
    sb.push_back(8'h77);
    spi_read(16'h0010, 1, "t3_nostore");
    spi_op(8'h06);
    chk("t3_wel_on", wel, 1'b1);
    spi_begin; cmd_byte(8'h05);
    sb.push_back(8'h02); sb.push_back(8'h02);
    read_bytes(2, "t3_rdsr");
    spi_end;
    spi_write(16'h0010, 32'h5A000000, 1);
    chk("t3_wel_clr", wel, 1'b0);
    sb.push_back(8'h5A);
    spi_read(16'h0010, 1, "t3_store");

    // 4: page wrap on write
    host_wr(15'h0040, 8'h55);
    spi_op(8'h06);
    spi_write(16'h003E, 32'hA0A1A2A3, 4);
    sb.push_back(8'hA0); sb.push_back(8'hA1);
    spi_read(16'h003E, 2, "t4_page_hi");
    sb.push_back(8'hA2); sb.push_back(8'hA3);
    spi_read(16'h0000, 2, "t4_page_lo");
    sb.push_back(8'h55);
    spi_read(16'h0040, 1, "t4_next_page");

    // 5: unknown opcode keeps miso undriven, then READ still works
    spi_begin; cmd_byte(8'h9F); cmd_byte(8'h00); cmd_byte(8'h00); spi_end;
    sb.push_back(8'hAB);
    spi_read(16'h7FFF, 1, "t5_after_ign");

    // 6a: WRITE aborted after 4 data bits
    host_wr(15'h0020, 8'h33);
    spi_op(8'h06);
    spi_begin; cmd_byte(8'h02); cmd_byte(8'h00); cmd_byte(8'h20);
    spi_bits(8'hFF, 4, rx, all, any);
    spi_end;
    chk("t6_wel_kept", wel, 1'b1);
    sb.push_back(8'h33);
    spi_read(16'h0020, 1, "t6_partial");
    spi_op(8'h04);
    chk("t6_wrdi", wel, 1'b0);

    // 6b: host write while ss low is dropped
    host_wr(15'h0021, 8'h44);
    spi_begin; host_wr(15'h0021, 8'hEE); spi_end;
    sb.push_back(8'h44);
    spi_read(16'h0021, 1, "t6_host_drop");

    // 6c: reset in the middle of a READ
    spi_op(8'h06);
    spi_begin; cmd_byte(8'h03); cmd_byte(8'h00); cmd_byte(8'h00);
    spi_bits(8'h00, 4, rx, all, any);
    chk("t6_oe_before", miso_oe, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_oe", miso_oe, 1'b0);
    chk("t6_rst_miso", miso, 1'b0);
    chk("t6_rst_wel", wel, 1'b0);
    tick(2);
    reset = 1'b0; ss = 1'b1; spi_clk = 1'b0;
    tick(8);
    chk("t6_rst_busy", busy, 1'b0);
    sb.push_back(8'hAB); sb.push_back(8'hA2);
    spi_read(16'h7FFF, 2, "t6_recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
